// File: rtl/sudoku_checker.sv
// Sudoku board verifier: streams all 81 cells three times (rows, columns, boxes)
// through a one-cycle-latency read port and reports the first offending cell.
module sudoku_checker #(
    parameter int SIZE = 9,
    parameter int AW   = 7
) (
    input  logic          clka,
    input  logic          restart,
    input  logic          dp_check,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [3:0]    rd_data,
    output logic          busy,
    output logic          done,
    output logic          solved,
    output logic [AW-1:0] fail_addr,
    output logic [1:0]    fail_phase
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [3:0] LAST = 4'(SIZE - 1);

    state_t state, state_nx;

    logic          dp_prev;
    logic [1:0]    p;
    logic [3:0]    u, k;
    logic [1:0]    np;
    logic [3:0]    nu, nk;
    logic          last_issue;
    logic [AW-1:0] next_addr;

    logic          tag_vld, tag_last;
    logic [1:0]    tag_p;
    logic [3:0]    tag_k;
    logic [AW-1:0] tag_addr;
    logic [8:0]    seen, onehot;
    logic          bad, viol, pass_end, start;

    function automatic logic [AW-1:0] cell_addr(input logic [1:0] ph,
                                                input logic [3:0] un,
                                                input logic [3:0] ce);
        logic [3:0] r, c;
        case (ph)
            2'd0: begin r = un; c = ce; end
            2'd1: begin r = ce; c = un; end
            default: begin
                r = 4'd3 * (un / 4'd3) + ce / 4'd3;
                c = 4'd3 * (un % 4'd3) + ce % 4'd3;
            end
        endcase
        return AW'(r) * AW'(SIZE) + AW'(c);
    endfunction

    // Counters describe the read currently on the bus; advance k fastest.
    always_comb begin
        np = p;
        nu = u;
        nk = k + 4'd1;
        if (k == LAST) begin
            nk = 4'd0;
            nu = u + 4'd1;
            if (u == LAST) begin
                nu = 4'd0;
                np = p + 2'd1;
            end
        end
        last_issue = (p == 2'd2) && (u == LAST) && (k == LAST);
        next_addr  = cell_addr(np, nu, nk);
    end

    // Check stage: rd_data lines up with the tag registered one cycle earlier.
    always_comb begin
        onehot   = 9'd1 << (rd_data - 4'd1);
        bad      = (rd_data == 4'd0) || (rd_data > 4'd9) ||
                   ((tag_k != 4'd0) && |(seen & onehot));
        viol     = (state == SCAN) && tag_vld && bad;
        pass_end = (state == SCAN) && tag_vld && tag_last && !bad;
        start    = (state == IDLE) && dp_check && !dp_prev;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SCAN;
            SCAN:    if (viol || pass_end) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (restart) state <= IDLE;
        else         state <= state_nx;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clka) begin
        if (restart) begin
            dp_prev    <= 1'b0;
            p          <= '0;
            u          <= '0;
            k          <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            tag_vld    <= 1'b0;
            tag_last   <= 1'b0;
            tag_p      <= '0;
            tag_k      <= '0;
            tag_addr   <= '0;
            seen       <= '0;
            done       <= 1'b0;
            solved     <= 1'b0;
            fail_addr  <= '0;
            fail_phase <= '0;
        end else begin
            dp_prev <= dp_check;
            done    <= 1'b0;
            tag_vld <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    solved     <= 1'b0;
                    fail_addr  <= '0;
                    fail_phase <= '0;
                    p          <= '0;
                    u          <= '0;
                    k          <= '0;
                    rd_en      <= 1'b1;
                    rd_addr    <= '0;
                end
                SCAN: begin
                    tag_vld  <= rd_en;
                    tag_last <= last_issue;
                    tag_p    <= p;
                    tag_k    <= k;
                    tag_addr <= rd_addr;
                    if (tag_vld)
                        seen <= (tag_k == 4'd0) ? onehot : (seen | onehot);
                    if (viol || pass_end) begin
                        // Any read issued this cycle is abandoned.
                        tag_vld    <= 1'b0;
                        rd_en      <= 1'b0;
                        rd_addr    <= '0;
                        done       <= 1'b1;
                        solved     <= pass_end;
                        fail_addr  <= viol ? tag_addr : '0;
                        fail_phase <= viol ? tag_p : 2'd0;
                    end else if (rd_en) begin
                        if (last_issue) begin
                            rd_en   <= 1'b0;
                            rd_addr <= '0;
                        end else begin
                            p       <= np;
                            u       <= nu;
                            k       <= nk;
                            rd_addr <= next_addr;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sudoku_checker.sv
// Directed bench for sudoku_checker: behavioural board RAM plus per-scenario tasks.
module tb_sudoku_checker;

    logic       clka = 1'b0;
    logic       restart, dp_check;
    logic       rd_en, busy, done, solved;
    logic [6:0] rd_addr, fail_addr;
    logic [3:0] rd_data;
    logic [1:0] fail_phase;

    logic [3:0] board [0:80];
    int         exp_addr [0:242];
    int         n_chk = 0;
    int         n_fail = 0;

    sudoku_checker #(.SIZE(9), .AW(7)) dut (
        .clka(clka), .restart(restart), .dp_check(dp_check),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .solved(solved),
        .fail_addr(fail_addr), .fail_phase(fail_phase)
    );

    always #5 clka = ~clka;

    always @(posedge clka) if (rd_en) rd_data <= board[rd_addr];

    task automatic load_ref();
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                board[r*9+c] = 4'(((3*r + r/3 + c) % 9) + 1);
    endtask

    // Starts a scan from an idle DUT and follows it until done (T = first cycle).
    task automatic run_scan(input bit hold, output int done_at, output int nreads,
                            output int addr_err);
        done_at = -1; nreads = 0; addr_err = 0;
        @(negedge clka); @(negedge clka);
        dp_check = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clka);
            if (!hold) dp_check = 1'b0;
            if (rd_en) begin
                if (nreads > 242 || n != nreads + 1 || int'(rd_addr) != exp_addr[nreads])
                    addr_err++;
                nreads++;
            end
            if (done) begin done_at = n; break; end
        end
    endtask

    task automatic chk_result(input string name, input int done_at, input int exp_done,
                              input bit exp_solved, input int exp_fa, input int exp_fp);
        n_chk++;
        if (done_at !== exp_done) begin
            n_fail++; $display("FAIL %s done_cycle got %0d want %0d", name, done_at, exp_done);
        end
        n_chk++;
        if (solved !== exp_solved || int'(fail_addr) !== exp_fa || int'(fail_phase) !== exp_fp) begin
            n_fail++;
            $display("FAIL %s verdict got solved=%0b addr=%0d phase=%0d want %0b/%0d/%0d",
                     name, solved, fail_addr, fail_phase, exp_solved, exp_fa, exp_fp);
        end
        n_chk++;
        if (rd_en !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL %s done_cycle rd_en=%0b busy=%0b want 0/1", name, rd_en, busy);
        end
    endtask

    task automatic test_reset();
        restart = 1'b1; dp_check = 1'b0;
        repeat (3) @(negedge clka);
        n_chk++;
        if ({rd_en, rd_addr, busy, done, solved, fail_addr, fail_phase} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs got en=%0b a=%0d b=%0b d=%0b s=%0b fa=%0d fp=%0d want all 0",
                     rd_en, rd_addr, busy, done, solved, fail_addr, fail_phase);
        end
        restart = 1'b0;
    endtask

    task automatic test_full_pass();
        int d, nr, ae;
        load_ref();
        run_scan(0, d, nr, ae);
        chk_result("full_pass", d, 245, 1'b1, 0, 0);
        n_chk++;
        if (nr !== 243 || ae !== 0) begin
            n_fail++; $display("FAIL full_pass reads got %0d (addr_err %0d) want 243 (0)", nr, ae);
        end
        repeat (5) @(negedge clka);
        n_chk++;
        if (solved !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL full_pass hold got solved=%0b busy=%0b done=%0b want 1/0/0",
                               solved, busy, done);
        end
    endtask

    task automatic test_empty_cell();
        int d, nr, ae;
        load_ref(); board[40] = 4'd0;
        run_scan(0, d, nr, ae);
        chk_result("empty_cell", d, 43, 1'b0, 40, 0);
        n_chk++;
        if (nr !== 42 || ae !== 0) begin
            n_fail++; $display("FAIL empty_cell reads got %0d (addr_err %0d) want 42 (0)", nr, ae);
        end
    endtask

    task automatic test_col_dup();
        int d, nr, ae;
        load_ref(); board[0] = 4'd2; board[1] = 4'd1;
        run_scan(0, d, nr, ae);
        chk_result("col_dup", d, 87, 1'b0, 27, 1);
    endtask

    task automatic test_bad_value();
        int d, nr, ae;
        load_ref(); board[80] = 4'd10;
        run_scan(0, d, nr, ae);
        chk_result("bad_value", d, 83, 1'b0, 80, 0);
    endtask

    task automatic test_box_fail();
        int d, nr, ae;
        // Cyclic Latin square: rows and columns valid, box 0 repeats 2 at (1,0).
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                board[r*9+c] = 4'(((r + c) % 9) + 1);
        run_scan(0, d, nr, ae);
        chk_result("box_fail", d, 168, 1'b0, 9, 2);
    endtask

    task automatic test_back_to_back();
        int d, nr, ae, extra;
        load_ref();
        run_scan(1, d, nr, ae);
        chk_result("hold_first", d, 245, 1'b1, 0, 0);
        extra = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clka);
            if (rd_en || busy || done) extra++;
        end
        n_chk++;
        if (extra !== 0) begin
            n_fail++; $display("FAIL hold_high extra_activity got %0d cycles want 0", extra);
        end
        dp_check = 1'b0;
        run_scan(0, d, nr, ae);
        chk_result("hold_second", d, 245, 1'b1, 0, 0);
        n_chk++;
        if (nr !== 243 || ae !== 0) begin
            n_fail++; $display("FAIL hold_second reads got %0d (addr_err %0d) want 243 (0)", nr, ae);
        end
    endtask

    task automatic test_restart_mid();
        int d, nr, ae, dones;
        load_ref();
        dones = 0;
        @(negedge clka); @(negedge clka);
        dp_check = 1'b1;
        for (int n = 1; n <= 350; n++) begin
            @(negedge clka);
            dp_check = 1'b0;
            if (n == 100) restart = 1'b1;
            if (n == 101) begin
                restart = 1'b0;
                n_chk++;
                if ({rd_en, rd_addr, busy, done, solved, fail_addr, fail_phase} !== '0) begin
                    n_fail++;
                    $display("FAIL restart_mid outputs got en=%0b a=%0d b=%0b d=%0b want all 0",
                             rd_en, rd_addr, busy, done);
                end
            end
            if (done) dones++;
        end
        n_chk++;
        if (dones !== 0) begin
            n_fail++; $display("FAIL restart_mid done_pulses got %0d want 0", dones);
        end
        run_scan(0, d, nr, ae);
        chk_result("after_restart", d, 245, 1'b1, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 81; i++) begin
            exp_addr[i]      = i;
            exp_addr[81+i]   = (i % 9) * 9 + i / 9;
            exp_addr[162+i]  = (3*((i/9)/3) + (i%9)/3) * 9 + 3*((i/9)%3) + (i%9)%3;
        end
        test_reset();
        test_full_pass();
        test_empty_cell();
        test_col_dup();
        test_bad_value();
        test_box_fail();
        test_back_to_back();
        test_restart_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
